// File: rtl/golden_nonce_arbiter_pkg.sv
// Shared miner constants: nonce width, pipeline offset derivation and the
// send-sequencer state encoding.
package golden_nonce_arbiter_pkg;

  localparam int LOOP_LOG2 = 2;
  localparam int NONCE_W   = 32;

  // The lane nonce runs ahead of the hit by the pipeline depth plus one.
  localparam logic [NONCE_W-1:0] NONCE_OFFSET = NONCE_W'((1 << (7 - LOOP_LOG2)) + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GUARD = 2'd2
  } send_state_t;

endpackage

// File: rtl/golden_nonce_arbiter_nonce_fifo.sv
// Circular result buffer with wrapping pointers; push and pop may coincide,
// including when full.
module nonce_fifo
  import golden_nonce_arbiter_pkg::*;
#(
  parameter int WIDTH = NONCE_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/golden_nonce_arbiter.sv
// Collects per-lane golden-ticket hits, corrects them by the pipeline offset,
// queues them round-robin and feeds the shared serial transmitter.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for a queued word and a non-busy transmitter
// ST_PULSE | serial_send high for one cycle, golden_nonce freshly loaded
// ST_GUARD | one dead cycle covering the transmitter's busy rise latency
module golden_nonce_arbiter
  import golden_nonce_arbiter_pkg::*;
#(
  parameter int                 LANES        = 2,
  parameter int                 FIFO_DEPTH   = 4,
  parameter logic [NONCE_W-1:0] NONCE_OFFSET = golden_nonce_arbiter_pkg::NONCE_OFFSET
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [LANES-1:0]            ticket,
  input  logic [NONCE_W*LANES-1:0]    lane_nonce,
  input  logic                        clear,
  input  logic                        serial_busy,
  output logic                        serial_send,
  output logic [NONCE_W-1:0]          golden_nonce,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] pending
);
  localparam int RR_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LANES-1:0]   hold_valid;
  logic [NONCE_W-1:0] hold_nonce [LANES];
  logic [LANES-1:0]   grant_vec, load_vec, drop_vec;
  logic [RR_W-1:0]    rr, grant_idx;
  logic [RR_W:0]      scan;
  logic               grant_any, grant_ok;
  logic               fifo_full, fifo_empty, pop;
  logic [NONCE_W-1:0] fifo_rdata;
  send_state_t        state, state_nx;

  // First valid lane at or after rr, scanning with wraparound.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    scan      = '0;
    grant_ok  = !clear && (!fifo_full || pop);
    for (int k = 0; k < LANES; k++) begin
      scan = {1'b0, rr} + (RR_W+1)'(k);
      if (scan >= (RR_W+1)'(LANES)) scan = scan - (RR_W+1)'(LANES);
      if (grant_ok && !grant_any && hold_valid[scan[RR_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = scan[RR_W-1:0];
      end
    end
    if (grant_any) grant_vec[grant_idx] = 1'b1;
  end

  // A lane being granted this cycle frees its hold slot for the new hit.
  assign load_vec = ticket & ~(hold_valid & ~grant_vec) & {LANES{~clear}};
  assign drop_vec = ticket & hold_valid & ~grant_vec;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_valid <= '0;
      overflow   <= 1'b0;
      rr         <= '0;
    end else if (clear) begin
      hold_valid <= '0;
      overflow   <= 1'b0;
      rr         <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (load_vec[i])       hold_valid[i] <= 1'b1;
        else if (grant_vec[i]) hold_valid[i] <= 1'b0;
      end
      if (|drop_vec) overflow <= 1'b1;
      if (grant_any) rr <= (grant_idx == RR_W'(LANES - 1)) ? '0 : grant_idx + RR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (load_vec[i]) hold_nonce[i] <= lane_nonce[i*NONCE_W +: NONCE_W] - NONCE_OFFSET;
    end
  end

  nonce_fifo #(
    .WIDTH (NONCE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .push    (grant_any),
    .wdata   (hold_nonce[grant_idx]),
    .pop     (pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (pending)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && !serial_busy && !clear) begin
          pop      = 1'b1;
          state_nx = ST_PULSE;
        end
      end
      ST_PULSE: state_nx = ST_GUARD;
      ST_GUARD: state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  golden_nonce <= '0;
    else if (pop)  golden_nonce <= fifo_rdata;
  end

  assign serial_send = (state == ST_PULSE);

endmodule

// File: tb/tb_golden_nonce_arbiter.sv
// Scenario bench for golden_nonce_arbiter with a queue-based reference model.
module tb_golden_nonce_arbiter;
  localparam int LANES = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  ticket = '0;
  logic [63:0] lane_nonce = '0;
  logic        clear = 1'b0;
  logic        serial_busy = 1'b0;
  wire         serial_send;
  wire  [31:0] golden_nonce;
  wire         overflow;
  wire  [2:0]  pending;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] dut_sends[$];
  int          send_cyc[$];
  logic [31:0] exp_sends[$];

  // reference model state
  logic [31:0] m_q[$];
  bit          m_hv[LANES];
  logic [31:0] m_hn[LANES];
  int          m_rr, m_cool, m_g;
  bit          m_ovf, m_pop;

  golden_nonce_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ticket       (ticket),
    .lane_nonce   (lane_nonce),
    .clear        (clear),
    .serial_busy  (serial_busy),
    .serial_send  (serial_send),
    .golden_nonce (golden_nonce),
    .overflow     (overflow),
    .pending      (pending)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset_n === 1'b1 && serial_send === 1'b1) begin
      dut_sends.push_back(golden_nonce);
      send_cyc.push_back(cyc);
    end
  end

  // A send is allowed when the queue has data, the link is idle and two
  // cycles have passed since the previous send.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      m_rr = 0; m_cool = 0; m_ovf = 0;
      for (int i = 0; i < LANES; i++) m_hv[i] = 0;
    end else begin
      m_pop = (m_cool == 0) && (m_q.size() != 0) && !serial_busy && !clear;
      m_g = -1;
      if (!clear && (m_q.size() < DEPTH || m_pop))
        for (int k = 0; k < LANES; k++)
          if (m_g < 0 && m_hv[(m_rr + k) % LANES]) m_g = (m_rr + k) % LANES;
      if (m_pop) begin
        exp_sends.push_back(m_q.pop_front());
        m_cool = 2;
      end else if (m_cool > 0) m_cool--;
      if (m_g >= 0) begin
        m_q.push_back(m_hn[m_g]);
        m_rr = (m_g + 1) % LANES;
      end
      if (clear) begin
        m_q.delete(); m_rr = 0; m_ovf = 0;
      end
      for (int i = 0; i < LANES; i++) begin
        if (clear) m_hv[i] = 0;
        else if (ticket[i]) begin
          if (m_hv[i] && m_g != i) m_ovf = 1;
          else begin
            m_hv[i] = 1;
            m_hn[i] = lane_nonce[32*i +: 32] - 32'd33;
          end
        end else if (m_g == i) m_hv[i] = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic hit(input int lane, input logic [31:0] nonce);
    ticket = '0;
    ticket[lane] = 1'b1;
    lane_nonce[32*lane +: 32] = nonce;
    step(1);
    ticket = '0;
    step(1);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(1);
  endtask

  task automatic flush_logs();
    dut_sends.delete();
    send_cyc.delete();
    exp_sends.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ticket = '0; lane_nonce = '0; clear = 1'b0; serial_busy = 1'b0;
    step(3);
    n_tests++; if (serial_send !== 1'b0) begin n_fail++; $display("FAIL reset_send: got %0b want 0", serial_send); end
    n_tests++; if (golden_nonce !== 32'h0) begin n_fail++; $display("FAIL reset_nonce: got %h want 0", golden_nonce); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
    n_tests++; if (pending !== 3'd0) begin n_fail++; $display("FAIL reset_pending: got %0d want 0", pending); end
    reset_n = 1'b1;
    step(2);
    n_tests++; if (pending !== 3'd0 || serial_send !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: pending %0d send %0b want 0 0", pending, serial_send); end
  endtask

  task automatic test_single_hit();
    int t0, waited;
    flush_logs();
    t0 = cyc;
    ticket = 2'b01; lane_nonce[31:0] = 32'h00001000;
    step(1);
    ticket = '0;
    waited = 0;
    while (dut_sends.size() == 0 && waited < 20) begin step(1); waited++; end
    n_tests++; if (dut_sends.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d sends want 1", dut_sends.size()); end
    if (dut_sends.size() >= 1) begin
      n_tests++; if (dut_sends[0] !== 32'h00000FDF) begin n_fail++; $display("FAIL single_value: got %h want 00000fdf", dut_sends[0]); end
      n_tests++; if (send_cyc[0] - t0 != 3) begin n_fail++; $display("FAIL single_latency: got %0d want 3", send_cyc[0] - t0); end
    end
    step(3);
    n_tests++; if (pending !== 3'd0) begin n_fail++; $display("FAIL single_pending: got %0d want 0", pending); end
  endtask

  task automatic test_simultaneous();
    pulse_clear();
    flush_logs();
    ticket = 2'b11; lane_nonce = {32'h80000100, 32'h00000100};
    step(1);
    ticket = '0;
    step(15);
    n_tests++; if (dut_sends.size() != 2) begin n_fail++; $display("FAIL simul_count: got %0d want 2", dut_sends.size()); end
    if (dut_sends.size() == 2) begin
      n_tests++; if (dut_sends[0] !== 32'h000000DF) begin n_fail++; $display("FAIL simul_first: got %h want 000000df", dut_sends[0]); end
      n_tests++; if (dut_sends[1] !== 32'h800000DF) begin n_fail++; $display("FAIL simul_second: got %h want 800000df", dut_sends[1]); end
      n_tests++; if (send_cyc[1] - send_cyc[0] < 3) begin n_fail++; $display("FAIL simul_gap: got %0d want >=3", send_cyc[1] - send_cyc[0]); end
    end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL simul_overflow: got %0b want 0", overflow); end
  endtask

  task automatic test_busy_stall();
    logic [31:0] hits[3];
    flush_logs();
    serial_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      hits[i] = $urandom | 32'h100;
      hit(int'($urandom_range(0, 1)), hits[i]);
    end
    step(44);
    n_tests++; if (dut_sends.size() != 0) begin n_fail++; $display("FAIL stall_no_send: got %0d sends want 0", dut_sends.size()); end
    n_tests++; if (pending !== 3'd3 || int'(pending) != m_q.size()) begin n_fail++; $display("FAIL stall_pending: got %0d want 3 (model %0d)", pending, m_q.size()); end
    serial_busy = 1'b0;
    step(20);
    n_tests++; if (dut_sends.size() != 3) begin n_fail++; $display("FAIL stall_count: got %0d want 3", dut_sends.size()); end
    for (int i = 0; i < 3 && i < dut_sends.size(); i++) begin
      n_tests++; if (dut_sends[i] !== hits[i] - 32'd33) begin n_fail++; $display("FAIL stall_order[%0d]: got %h want %h", i, dut_sends[i], hits[i] - 32'd33); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] hits[5];
    pulse_clear();
    flush_logs();
    serial_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hits[i] = $urandom | 32'h100;
      hit(int'($urandom_range(0, 1)), hits[i]);
    end
    step(2);
    n_tests++; if (pending !== 3'd4) begin n_fail++; $display("FAIL full_pending: got %0d want 4", pending); end
    hits[4] = $urandom | 32'h100;
    hit(1, hits[4]);
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL held_overflow: got %0b want 0", overflow); end
    hit(1, $urandom | 32'h100);
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL drop_overflow: got %0b want 1", overflow); end
    n_tests++; if (pending !== 3'd4) begin n_fail++; $display("FAIL drop_pending: got %0d want 4", pending); end
    serial_busy = 1'b0;
    step(40);
    n_tests++; if (dut_sends.size() != 5) begin n_fail++; $display("FAIL drain_count: got %0d want 5", dut_sends.size()); end
    for (int i = 0; i < 5 && i < dut_sends.size(); i++) begin
      n_tests++; if (dut_sends[i] !== hits[i] - 32'd33) begin n_fail++; $display("FAIL drain_word[%0d]: got %h want %h", i, dut_sends[i], hits[i] - 32'd33); end
    end
  endtask

  task automatic test_wrap_fairness();
    pulse_clear();
    flush_logs();
    serial_busy = 1'b0;
    for (int c = 0; c < 20; c++) begin
      ticket = 2'b11;
      lane_nonce[31:0]  = ($urandom & 32'h7FFFFFFF) | 32'h100;
      lane_nonce[63:32] = $urandom | 32'h80000100;
      step(1);
    end
    ticket = '0;
    step(40);
    n_tests++; if (dut_sends.size() != exp_sends.size() || dut_sends.size() < 6) begin n_fail++; $display("FAIL wrap_count: got %0d want %0d (>=6)", dut_sends.size(), exp_sends.size()); end
    for (int i = 0; i < dut_sends.size() && i < exp_sends.size(); i++) begin
      n_tests++; if (dut_sends[i] !== exp_sends[i]) begin n_fail++; $display("FAIL wrap_word[%0d]: got %h want %h", i, dut_sends[i], exp_sends[i]); end
      n_tests++; if (dut_sends[i][31] !== 1'(i % 2)) begin n_fail++; $display("FAIL fair_lane[%0d]: got lane %0b want %0d", i, dut_sends[i][31], i % 2); end
    end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL wrap_overflow: got %0b want 1", overflow); end
    n_tests++; if (pending !== 3'd0) begin n_fail++; $display("FAIL wrap_pending: got %0d want 0", pending); end
    flush_logs();
    hit(0, 32'h00000005);
    step(6);
    n_tests++; if (dut_sends.size() != 1 || dut_sends[0] !== 32'hFFFFFFE4) begin n_fail++; $display("FAIL underflow_word: got %0d sends, first %h want 1 ffffffe4", dut_sends.size(), (dut_sends.size() > 0) ? dut_sends[0] : 32'h0); end
  endtask

  task automatic test_clear_reset();
    int waited;
    flush_logs();
    serial_busy = 1'b1;
    hit(0, $urandom | 32'h100);
    hit(1, $urandom | 32'h100);
    step(1);
    n_tests++; if (pending !== 3'd2) begin n_fail++; $display("FAIL clear_pre_pending: got %0d want 2", pending); end
    clear = 1'b1; ticket = 2'b11;
    step(1);
    clear = 1'b0; ticket = '0;
    step(1);
    n_tests++; if (pending !== 3'd0) begin n_fail++; $display("FAIL clear_pending: got %0d want 0", pending); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clear_overflow: got %0b want 0", overflow); end
    step(2);
    n_tests++; if (pending !== 3'd0) begin n_fail++; $display("FAIL clear_ticket_discard: got %0d want 0", pending); end
    serial_busy = 1'b0;
    step(10);
    n_tests++; if (dut_sends.size() != 0) begin n_fail++; $display("FAIL clear_no_send: got %0d want 0", dut_sends.size()); end

    hit(0, $urandom | 32'h100);
    waited = 0;
    while (serial_send !== 1'b1 && waited < 10) begin step(1); waited++; end
    n_tests++;
    if (serial_send !== 1'b1) begin
      n_fail++; $display("FAIL reset_pulse_timeout: send %0b want 1 within 10 cycles", serial_send);
    end else begin
      reset_n = 1'b0;
      #1;
      n_tests++; if (serial_send !== 1'b0) begin n_fail++; $display("FAIL async_send: got %0b want 0", serial_send); end
      n_tests++; if (golden_nonce !== 32'h0) begin n_fail++; $display("FAIL async_nonce: got %h want 0", golden_nonce); end
      n_tests++; if (pending !== 3'd0) begin n_fail++; $display("FAIL async_pending: got %0d want 0", pending); end
    end
    step(2);
    reset_n = 1'b1;
    step(4);
    n_tests++; if (serial_send !== 1'b0 || pending !== 3'd0) begin n_fail++; $display("FAIL after_reset_quiet: send %0b pending %0d want 0 0", serial_send, pending); end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_simultaneous();
    test_busy_stall();
    test_overflow();
    test_wrap_fairness();
    test_clear_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/golden_nonce_arbiter.md
# golden_nonce_arbiter

Collects golden-ticket hits from the parallel hasher lanes, corrects each hit nonce by the pipeline offset, and queues the results. It drives the single shared `serial_transmit` instance through its `send`/`busy` handshake, one word at a time. It sits between the lane comparators in the miner top level and the serial transmitter. Simultaneous hits from several lanes are queued in order; none is overwritten.

## Interface
- `LANES`, 2: number of hasher lanes; valid range 1–8.
- `FIFO_DEPTH`, 4: number of result entries; must be a power of two, 2–16.
- `NONCE_OFFSET`, 32'd33: value subtracted from the lane nonce to recover the hit nonce (equals 2^(7-LOOP_LOG2)+1).

- `clk`  in  1  hash clock; all logic is rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ticket`  in  LANES  per-lane golden-ticket strobe; may be high on consecutive cycles.
- `lane_nonce`  in  32*LANES  current nonce of each lane; lane i occupies bits [32i+31:32i].
- `clear`  in  1  synchronous flush, pulsed on new work.
- `serial_busy`  in  1  busy flag from the transmitter.
- `serial_send`  out  1  single-cycle send strobe to the transmitter.
- `golden_nonce`  out  32  word to transmit; held stable until the next send.
- `overflow`  out  1  sticky flag: at least one hit was dropped.
- `pending`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- **Capture:** for each lane i, when `ticket[i]` is high, set `hold_valid[i]` and load `hold_nonce[i] = lane_nonce[i] - NONCE_OFFSET`. Arithmetic is 32-bit modulo, so 0 - 33 gives 32'hFFFFFFDF.
  - Drop rule: if `ticket[i]` is high while `hold_valid[i]` is set and lane i is not granted that cycle, keep the old value, discard the new hit and set `overflow`.
  - If lane i is granted in the same cycle, load the new hit with no drop.
- **Arbitration:** round-robin pointer `rr`.
  - Each cycle, when the FIFO is not full or a pop occurs that cycle, grant the first valid lane at or after `rr`.
  - On a grant: push that lane's nonce, clear its `hold_valid`, and set `rr` to the granted lane + 1 (mod LANES).
  - At most one push per cycle.
- **FIFO:** circular buffer with wrapping read/write pointers. Push and pop in the same cycle is allowed at any occupancy ≥ 1. When full with no pop, there is no push and holds stall.
- **Send FSM:** states IDLE, PULSE, GUARD.
  - IDLE: when `pending != 0` and `!serial_busy`, pop, load `golden_nonce`, assert `serial_send`, go to PULSE.
  - PULSE: deassert `serial_send`, go to GUARD.
  - GUARD: one cycle that masks the transmitter's busy rise latency, then go to IDLE.
- **clear:** empties the FIFO, clears all `hold_valid`, clears `overflow`, and resets `rr` to 0.
  - An in-flight PULSE/GUARD sequence completes; `golden_nonce` is kept.
  - A ticket in the same cycle as `clear` is discarded.
- **Reset values:** `serial_send`=0, `golden_nonce`=0, `overflow`=0, `pending`=0, state IDLE, `rr`=0, all `hold_valid`=0.

## Timing
- Ticket sampled at edge t → hold register set at t → FIFO push at t+1 → pop at t+2. `serial_send` is high for exactly the cycle after edge t+2. Minimum latency is 3 cycles.
- Back-to-back sends are at least 3 cycles apart (IDLE→PULSE→GUARD→IDLE). Each send additionally waits for `serial_busy` to be low.
- `golden_nonce` is valid in the `serial_send` cycle and is held until the next pop.
- `overflow` is set in the cycle after the dropping ticket.
- `pending` reflects occupancy after the current edge. Simultaneous push and pop leaves it unchanged.
- `reset_n` deasserted mid-transfer: all state returns to reset values immediately (asynchronous). The transmitter is not informed.

## Structure
- The shared miner package holds `NONCE_OFFSET` derivation from `LOOP_LOG2`, the nonce width localparam (32) and the FSM state encoding.
- One sub-module, `nonce_fifo`: parameterised width/depth with push/pop/full/empty/count.
- The round-robin grant is inline.
- Top-level replacement: the per-lane `is_golden_ticket_*` registers feed `ticket` directly.

## Test plan
- Single hit: lane 0 ticket with `lane_nonce`=32'h00001000 and busy low → `serial_send` pulses 3 cycles later with `golden_nonce`=32'h00000FDF; `pending` returns to 0.
- Simultaneous hits: both lanes in one cycle with nonces 32'h00000100 and 32'h80000100 → two sends, 32'h000000DF then 32'h800000DF, at least 3 cycles apart; `overflow`=0.
- Busy stall: hold `serial_busy`=1 for 50 cycles with 3 hits queued → no `serial_send` during the stall; after release, three sends in FIFO order.
- Full/overflow: busy high, 4 hits fill the FIFO, then 2 more hits on lane 1 → first extra hit is held, second is dropped; `overflow`=1 and `pending`=4. After busy falls, exactly 5 words are sent.
- Wrap and fairness: continuous tickets on both lanes for 20 cycles with busy low → grants alternate 0,1,0,1; pointer wraparound is correct; `lane_nonce`=32'h00000005 yields 32'hFFFFFFE4.
- Clear and reset: `clear` with 2 entries pending and a ticket in the same cycle → `pending`=0, `overflow`=0, no further sends. Asserting `reset_n` low during PULSE → `serial_send`=0 and `golden_nonce`=0 immediately.
